// File: rtl/sram22_1024x32_arb2_if.sv
// Request/response bundle for one requester of the 1024x32 SRAM arbiter.
// The bus master drives requests and accepts responses; the arbiter is the slave.
interface sram22_1024x32_arb2_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_wmask;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_wmask, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_wmask, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram22_1024x32_arb2.sv
// Two-port round-robin arbiter in front of a single-port 1024x32 byte-masked SRAM macro.
// One access per cycle; read data returns through a held per-port response register.
module sram22_1024x32_arb2 (
    input  logic                        clk,
    input  logic                        rst_n,
    sram22_1024x32_arb2_if.slave        p0,
    sram22_1024x32_arb2_if.slave        p1,
    output logic                        sram_we_o,
    output logic [3:0]                  sram_wmask_o,
    output logic [9:0]                  sram_addr_o,
    output logic [31:0]                 sram_din_o,
    input  logic [31:0]                 sram_dout_i
);

    logic [1:0]        req_valid_s;
    logic [1:0]        req_we_s;
    logic [1:0]        rsp_ready_s;
    logic [1:0]        elig_s;
    logic [1:0]        grant_s;
    logic [1:0]        read_grant_s;

    logic [1:0]        pending_q,      pending_d;
    logic              inflight_vld_q, inflight_vld_d;
    logic              inflight_prt_q, inflight_prt_d;
    logic              last_grant_q,   last_grant_d;
    logic [1:0]        rsp_valid_q,    rsp_valid_d;
    logic [1:0][31:0]  rsp_rdata_q,    rsp_rdata_d;

    // Gather per-port request fields and compute eligibility from registered pending only
    always_comb begin
        req_valid_s  = {p1.req_valid, p0.req_valid};
        req_we_s     = {p1.req_we,    p0.req_we};
        rsp_ready_s  = {p1.rsp_ready, p0.rsp_ready};
        elig_s       = req_valid_s & (req_we_s | ~pending_q);
    end

    // Round-robin grant; nothing is granted while reset is asserted
    always_comb begin
        grant_s = 2'b00;
        if (!rst_n) begin
            grant_s = 2'b00;
        end else begin
            case (elig_s)
                2'b01:   grant_s = 2'b01;
                2'b10:   grant_s = 2'b10;
                2'b11:   grant_s = last_grant_q ? 2'b01 : 2'b10;
                default: grant_s = 2'b00;
            endcase
        end
        read_grant_s = grant_s & ~req_we_s;
    end

    // Macro drive; an idle cycle issues a harmless read at port 0's address
    always_comb begin
        sram_we_o    = 1'b0;
        sram_wmask_o = 4'h0;
        sram_addr_o  = p0.req_addr;
        sram_din_o   = p0.req_wdata;
        if (grant_s[1]) begin
            sram_we_o    = p1.req_we;
            sram_wmask_o = p1.req_wmask;
            sram_addr_o  = p1.req_addr;
            sram_din_o   = p1.req_wdata;
        end else if (grant_s[0]) begin
            sram_we_o    = p0.req_we;
            sram_wmask_o = p0.req_wmask;
            sram_addr_o  = p0.req_addr;
            sram_din_o   = p0.req_wdata;
        end else begin
            sram_we_o    = 1'b0;
            sram_wmask_o = 4'h0;
        end
    end

    // Next-state for arbitration history, pending reads and the response registers
    always_comb begin
        if (grant_s[1]) begin
            last_grant_d = 1'b1;
        end else if (grant_s[0]) begin
            last_grant_d = 1'b0;
        end else begin
            last_grant_d = last_grant_q;
        end

        inflight_vld_d = |read_grant_s;
        inflight_prt_d = read_grant_s[1];

        pending_d   = pending_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        for (int n = 0; n < 2; n++) begin
            if (read_grant_s[n]) begin
                pending_d[n] = 1'b1;
            end else if (rsp_valid_q[n] && rsp_ready_s[n]) begin
                pending_d[n] = 1'b0;
            end else begin
                pending_d[n] = pending_q[n];
            end

            // Only a read issued last cycle for this port may load its response register
            if (inflight_vld_q && (inflight_prt_q == 1'(n))) begin
                rsp_valid_d[n] = 1'b1;
                rsp_rdata_d[n] = sram_dout_i;
            end else if (rsp_valid_q[n] && rsp_ready_s[n]) begin
                rsp_valid_d[n] = 1'b0;
            end else begin
                rsp_valid_d[n] = rsp_valid_q[n];
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q      <= 2'b00;
            inflight_vld_q <= 1'b0;
            inflight_prt_q <= 1'b0;
            last_grant_q   <= 1'b1;
            rsp_valid_q    <= 2'b00;
            rsp_rdata_q    <= {2{32'h0000_0000}};
        end else begin
            pending_q      <= pending_d;
            inflight_vld_q <= inflight_vld_d;
            inflight_prt_q <= inflight_prt_d;
            last_grant_q   <= last_grant_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
        end
    end

    assign p0.req_ready = grant_s[0];
    assign p1.req_ready = grant_s[1];
    assign p0.rsp_valid = rsp_valid_q[0];
    assign p1.rsp_valid = rsp_valid_q[1];
    assign p0.rsp_rdata = rsp_rdata_q[0];
    assign p1.rsp_rdata = rsp_rdata_q[1];

endmodule
